axil_regfile_slave: RTL and testbench

Parametrised AXI-Lite slave terminating all five channels of the team's AXI-Lite interface, backed by a configurable bank of NUM_REGS data-wide registers.
- Supports byte strobes, per-register read-only masking, and out-of-range / read-only error responses.
- AW and W channels are accepted independently and in any order.
- Serves as the standard DUT endpoint and CSR block behind the AXI-Lite agent.

---
 rtl/axil_regfile_slave_pkg.sv | 22 ++
 rtl/axil_regfile_slave_if.sv | 50 +++++
 rtl/axil_regfile_slave_core.sv | 85 ++++++++
 rtl/axil_regfile_slave.sv | 163 ++++++++++++++++
 tb/tb_axil_regfile_slave.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_regfile_slave_pkg.sv
// Shared AXI-Lite types for the register-file slave.
// Response codes, write-path phases and the address offset helper.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    RESP = 2'b10
  } wr_state_e;

  function automatic int offs_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI-Lite bus bundle: AW, W, B, AR and R channels.
// Master drives requests, slave drives readies and responses.
interface axil_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_regfile_slave_core.sv
// Register bank: address decode, byte-strobe merge,
// read-only masking and combinational read mux.
module axil_regfile_core
  import axil_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [NUM_REGS-1:0]     wr_hit,
  output logic                    wr_ok,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_ok
);

  localparam int OFFS = offs_of(DATA_WIDTH);
  localparam int NB   = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] ridx;
  logic [NUM_REGS-1:0]   wsel;
  logic [NUM_REGS-1:0]   rsel;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] nw,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
    end
    return r;
  endfunction

  // Sub-word address bits fall away here; no alignment check.
  assign widx = waddr >> OFFS;
  assign ridx = raddr >> OFFS;

  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel[i] = (widx == ADDR_WIDTH'(i));
      rsel[i] = (ridx == ADDR_WIDTH'(i));
    end
  end

  assign wr_hit = wsel & ~RO_MASK;
  assign wr_ok  = |wr_hit;
  assign rd_ok  = |rsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= merge(regs[i], wdata, wstrb);
        end
      end
    end
  end

  // Out-of-range index selects nothing and reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsel[i]) rdata = rdata | regs[i];
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI-Lite slave over a parametrised register bank.
// Independent AW/W holds, one outstanding write and one read.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  axil_if.slave               bus,
  output logic [NUM_REGS-1:0] wr_pulse
);

  localparam int NB = DATA_WIDTH / 8;

  wr_state_e state;
  wr_state_e state_n;

  logic                  aw_held;
  logic                  w_held;
  logic                  aw_held_n;
  logic                  w_held_n;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  bvalid;
  logic                  bvalid_n;
  logic                  awready_q;
  logic                  wready_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_REGS-1:0]   wr_hit;
  logic                  wr_ok;
  logic                  rd_ok;
  resp_e                 bresp_q;
  resp_e                 rresp_q;

  assign aw_hs = bus.awvalid && awready_q;
  assign w_hs  = bus.wvalid && wready_q;
  assign ar_hs = bus.arvalid && arready_q;

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      state     <= state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      awready_q <= !aw_held_n && !bvalid_n;
      wready_q  <= !w_held_n && !bvalid_n;
    end
  end

  always_comb begin
    aw_held_n = (aw_held || aw_hs) && !commit;
    w_held_n  = (w_held || w_hs) && !commit;
    state_n   = state;
    unique case (state)
      IDLE:    if (aw_held_n && w_held_n) state_n = HOLD;
      HOLD:    state_n = RESP;
      RESP:    if (bus.bready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    bvalid_n = (state_n == RESP);
  end

  always_comb begin
    commit = 1'b0;
    bvalid = 1'b0;
    unique case (state)
      HOLD:    commit = 1'b1;
      RESP:    bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) aw_addr <= bus.awaddr;
      if (w_hs) begin
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
    end
  end

  // Pulse and response are decided on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse <= '0;
      bresp_q  <= OKAY;
    end else begin
      wr_pulse <= commit ? wr_hit : '0;
      if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
    end
  end

  // Read samples the bank before any same-edge commit lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else if (ar_hs) begin
      rvalid_q  <= 1'b1;
      arready_q <= 1'b0;
      rdata_q   <= rd_word;
      rresp_q   <= rd_ok ? OKAY : SLVERR;
    end else if (rvalid_q && bus.rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      arready_q <= !rvalid_q;
    end
  end

  axil_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit),
    .waddr  (aw_addr),
    .wdata  (w_data),
    .wstrb  (w_strb),
    .wr_hit (wr_hit),
    .wr_ok  (wr_ok),
    .raddr  (bus.araddr),
    .rdata  (rd_word),
    .rd_ok  (rd_ok)
  );

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave: vector table, corner sequences
// and random traffic against an array-based register model.
module tb_axil_regfile_slave;

  localparam logic [15:0] RO = 16'h8000;

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_pulse;

  int total;
  int bad;

  axil_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axil_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .NUM_REGS   (16),
    .RO_MASK    (RO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .wr_pulse (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] m [16];

  function automatic logic [1:0] mwrite(
    input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    i = int'(a[15:2]);
    if (i >= 16) return 2'b10;
    if (RO[i]) return 2'b10;
    for (int k = 0; k < 4; k++)
      if (s[k]) m[i][8*k +: 8] = d[8*k +: 8];
    return 2'b00;
  endfunction

  task automatic mread(input logic [15:0] a,
    output logic [31:0] d, output logic [1:0] r);
    int i;
    i = int'(a[15:2]);
    if (i >= 16) begin d = '0; r = 2'b10; end
    else begin d = m[i]; r = 2'b00; end
  endtask

  task automatic chk(input string n,
    input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d,
    input logic [3:0] s, input int lead,
    output logic [1:0] resp, output logic [15:0] pulses,
    output int npulse, output int lat, output bit hs_ok);
    bit aw_done, w_done, aw_go, w_go;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    pulses = '0; npulse = 0; lat = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= (lead > 0 ? lead : 0));
      bus.wvalid  = !w_done && (cyc >= (lead < 0 ? -lead : 0));
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      tick();
      cyc++;
      aw_done |= aw_go;
      w_done  |= w_go;
      if (wr_pulse != 0) begin pulses |= wr_pulse; npulse++; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    hs_ok = aw_done && w_done;
    bus.bready = 1'b1;
    while (!bus.bvalid && lat < 20) begin
      tick();
      lat++;
      if (wr_pulse != 0) begin pulses |= wr_pulse; npulse++; end
    end
    resp = bus.bresp;
    tick();
    if (wr_pulse != 0) begin pulses |= wr_pulse; npulse++; end
    bus.bready = 1'b0;
  endtask

  task automatic check_write(input string n, input logic [15:0] a,
    input logic [31:0] d, input logic [3:0] s, input int lead,
    input logic [1:0] er);
    logic [1:0]  resp;
    logic [15:0] pulses;
    logic [15:0] ep;
    int          npulse, lat;
    bit          hs_ok;
    do_write(a, d, s, lead, resp, pulses, npulse, lat, hs_ok);
    ep = (er == 2'b00) ? (16'h1 << a[15:2]) : 16'h0;
    chk({n, "_hs"}, 64'(hs_ok), 64'd1);
    chk({n, "_blat"}, 64'(lat), 64'd1);
    chk({n, "_bresp"}, 64'(resp), 64'(er));
    chk({n, "_pulse"}, 64'(pulses), 64'(ep));
    chk({n, "_npulse"}, 64'(npulse), (ep != 0) ? 64'd1 : 64'd0);
    chk({n, "_bdrop"}, 64'(bus.bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d,
    output logic [1:0] r, output bit ok);
    int cyc;
    bit go;
    cyc = 0; go = 0;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    while (!go && cyc < 20) begin
      go = bus.arready;
      tick();
      cyc++;
    end
    bus.arvalid = 1'b0;
    ok = go && bus.rvalid;
    d = bus.rdata;
    r = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic check_read(input string n, input logic [15:0] a,
    input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    do_read(a, d, r, ok);
    chk({n, "_rlat"}, 64'(ok), 64'd1);
    chk({n, "_rdata"}, 64'(d), 64'(ed));
    chk({n, "_rresp"}, 64'(r), 64'(er));
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lead;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] d, ed, r_d0;
    logic [1:0]  er, b0, r_r0;
    logic [15:0] a;
    logic [3:0]  s;
    int          lead;

    total = 0; bad = 0;
    for (int i = 0; i < 16; i++) m[i] = '0;

    tbl[0]  = '{1, 16'h0004, 32'hDEADBEEF, 4'hF,  0, 2'b00, 32'h0};
    tbl[1]  = '{0, 16'h0004, 32'h0,        4'h0,  0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1, 16'h0008, 32'h11223344, 4'hF,  0, 2'b00, 32'h0};
    tbl[3]  = '{1, 16'h0008, 32'hAABBCCDD, 4'h5,  3, 2'b00, 32'h0};
    tbl[4]  = '{0, 16'h0008, 32'h0,        4'h0,  0, 2'b00, 32'h11BB33DD};
    tbl[5]  = '{1, 16'h0040, 32'hCAFEF00D, 4'hF,  0, 2'b10, 32'h0};
    tbl[6]  = '{0, 16'h0040, 32'h0,        4'h0,  0, 2'b10, 32'h0};
    tbl[7]  = '{1, 16'h003C, 32'h12345678, 4'hF,  0, 2'b10, 32'h0};
    tbl[8]  = '{0, 16'h003C, 32'h0,        4'h0,  0, 2'b00, 32'h0};
    tbl[9]  = '{1, 16'h0006, 32'h0000FFFF, 4'h3, -2, 2'b00, 32'h0};
    tbl[10] = '{0, 16'h0005, 32'h0,        4'h0,  0, 2'b00, 32'hDEADFFFF};
    tbl[11] = '{1, 16'h000C, 32'hFFFFFFFF, 4'h0,  0, 2'b00, 32'h0};
    tbl[12] = '{0, 16'h000C, 32'h0,        4'h0,  0, 2'b00, 32'h0};

    rst_n = 1'b0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arvalid = 0;
    bus.rready = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_bresp", 64'(bus.bresp), 64'd0);
    chk("rst_rresp", 64'(bus.rresp), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_pulse", 64'(wr_pulse), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_awready_pre", 64'(bus.awready), 64'd0);
    tick();
    chk("rel_awready", 64'(bus.awready), 64'd1);
    chk("rel_wready", 64'(bus.wready), 64'd1);
    chk("rel_arready", 64'(bus.arready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) begin
        void'(mwrite(tbl[i].a, tbl[i].d, tbl[i].s));
        check_write($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d,
          tbl[i].s, tbl[i].lead, tbl[i].er);
      end else begin
        check_read($sformatf("tbl%0d", i), tbl[i].a, tbl[i].ed, tbl[i].er);
      end
    end

    // Back-pressure on B and R with new requests offered.
    bus.awaddr = 16'h0010; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    bus.araddr = 16'h0004; bus.arvalid = 1;
    tick();
    void'(mwrite(16'h0010, 32'h0BADF00D, 4'hF));
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    tick();
    b0 = bus.bresp; r_d0 = bus.rdata; r_r0 = bus.rresp;
    chk("stall_bresp", 64'(b0), 64'd0);
    chk("stall_rdata", 64'(r_d0), 64'hDEADFFFF);
    chk("stall_rresp", 64'(r_r0), 64'd0);
    bus.awaddr = 16'h0018; bus.wdata = 32'h77777777;
    bus.awvalid = 1; bus.wvalid = 1;
    bus.araddr = 16'h0008; bus.arvalid = 1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_bvalid", 64'(bus.bvalid), 64'd1);
      chk("stall_rvalid", 64'(bus.rvalid), 64'd1);
      chk("stall_bresp_hold", 64'(bus.bresp), 64'(b0));
      chk("stall_rdata_hold", 64'(bus.rdata), 64'(r_d0));
      chk("stall_rresp_hold", 64'(bus.rresp), 64'(r_r0));
      chk("stall_awready", 64'(bus.awready), 64'd0);
      chk("stall_wready", 64'(bus.wready), 64'd0);
      chk("stall_arready", 64'(bus.arready), 64'd0);
      tick();
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_no_extra_b", 64'(bus.bvalid), 64'd0);
      chk("stall_no_extra_r", 64'(bus.rvalid), 64'd0);
      tick();
    end
    check_read("stall_reg6", 16'h0018, 32'h0, 2'b00);

    // Commit and AR to the same register on one edge.
    bus.awaddr = 16'h0014; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    chk("col_aw_ready", 64'(bus.awready && bus.wready), 64'd1);
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 16'h0014; bus.arvalid = 1;
    chk("col_arready", 64'(bus.arready), 64'd1);
    tick();
    bus.arvalid = 0;
    chk("col_bvalid", 64'(bus.bvalid), 64'd1);
    chk("col_rvalid", 64'(bus.rvalid), 64'd1);
    chk("col_old_data", 64'(bus.rdata), 64'h0);
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    void'(mwrite(16'h0014, 32'h5A5A5A5A, 4'hF));
    check_read("col_new", 16'h0014, 32'h5A5A5A5A, 2'b00);

    for (int n = 0; n < 60; n++) begin
      a = 16'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        lead = int'($urandom_range(0, 6)) - 3;
        er = mwrite(a, d, s);
        check_write("rnd_wr", a, d, s, lead, er);
      end else begin
        mread(a, ed, er);
        check_read("rnd_rd", a, ed, er);
      end
    end

    // Reset with a held AW and an unconsumed R.
    bus.awaddr = 16'h0004; bus.awvalid = 1;
    tick();
    bus.awvalid = 0;
    bus.araddr = 16'h0008; bus.arvalid = 1;
    tick();
    bus.arvalid = 0;
    chk("mid_rvalid_pending", 64'(bus.rvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_awready", 64'(bus.awready), 64'd0);
    chk("mid_wready", 64'(bus.wready), 64'd0);
    chk("mid_arready", 64'(bus.arready), 64'd0);
    chk("mid_bvalid", 64'(bus.bvalid), 64'd0);
    chk("mid_rvalid", 64'(bus.rvalid), 64'd0);
    chk("mid_rdata", 64'(bus.rdata), 64'd0);
    chk("mid_rresp", 64'(bus.rresp), 64'd0);
    chk("mid_bresp", 64'(bus.bresp), 64'd0);
    chk("mid_pulse", 64'(wr_pulse), 64'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m[i] = '0;
    tick();
    bus.bready = 1; bus.rready = 1;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1;
    chk("mid_wready_back", 64'(bus.wready), 64'd1);
    tick();
    bus.wvalid = 0;
    for (int c = 0; c < 5; c++) begin
      chk("mid_no_b", 64'(bus.bvalid), 64'd0);
      chk("mid_no_r", 64'(bus.rvalid), 64'd0);
      tick();
    end
    bus.bready = 0; bus.rready = 0;
    check_read("mid_cleared1", 16'h0004, 32'h0, 2'b00);
    check_read("mid_cleared6", 16'h0014, 32'h0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
